// File: rtl/qspi_flex_fifo.sv
// Synchronous FIFO for the QSPI TX/RX data paths. Read mode is selectable (registered or FWFT).
// Thresholds are programmable at runtime, and the error flags are sticky.
module qspi_flex_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [CW-1:0]         level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_full    = (r_level == CW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    // Flush masks both requests, so no acceptance or error can occur in a flush cycle.
    assign w_rd_acc  = rd_en && !w_empty && !flush;
    assign w_wr_acc  = wr_en && !flush && (!w_full || w_rd_acc);
    assign w_ovf_set = wr_en && !flush && !w_wr_acc;
    assign w_unf_set = rd_en && !flush && w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + CW'(1);
                2'b01:   r_level <= r_level - CW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                end else if (flush) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end
            assign rd_data = r_rd_data;
        end
    endgenerate

    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= af_thresh);
    assign almost_empty = (r_level <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_qspi_flex_fifo.sv
// Bench for qspi_flex_fifo: a DEPTH=8 registered-read instance and a DEPTH=4 FWFT instance.
module tb_qspi_flex_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: DEPTH=8, FWFT=0, CW=4
    logic       d0_wr_en = 0, d0_rd_en = 0, d0_flush = 0, d0_err_clr = 0;
    logic [7:0] d0_wr_data = '0, d0_rd_data;
    logic [3:0] d0_af = 4'd8, d0_ae = 4'd0, d0_level;
    logic       d0_full, d0_empty, d0_afl, d0_aem, d0_ovf, d0_unf;

    // Instance 1: DEPTH=4, FWFT=1, CW=3
    logic       d1_wr_en = 0, d1_rd_en = 0, d1_flush = 0, d1_err_clr = 0;
    logic [7:0] d1_wr_data = '0, d1_rd_data;
    logic [2:0] d1_af = 3'd4, d1_ae = 3'd0, d1_level;
    logic       d1_full, d1_empty, d1_afl, d1_aem, d1_ovf, d1_unf;

    logic [7:0] sb [$];
    logic [7:0] exp_d;

    qspi_flex_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(d0_wr_en), .wr_data(d0_wr_data),
        .rd_en(d0_rd_en), .rd_data(d0_rd_data), .flush(d0_flush), .err_clr(d0_err_clr),
        .af_thresh(d0_af), .ae_thresh(d0_ae), .level(d0_level), .full(d0_full),
        .empty(d0_empty), .almost_full(d0_afl), .almost_empty(d0_aem),
        .overflow(d0_ovf), .underflow(d0_unf)
    );

    qspi_flex_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(d1_wr_en), .wr_data(d1_wr_data),
        .rd_en(d1_rd_en), .rd_data(d1_rd_data), .flush(d1_flush), .err_clr(d1_err_clr),
        .af_thresh(d1_af), .ae_thresh(d1_ae), .level(d1_level), .full(d1_full),
        .empty(d1_empty), .almost_full(d1_afl), .almost_empty(d1_aem),
        .overflow(d1_ovf), .underflow(d1_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill0(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            d0_wr_en = 1; d0_wr_data = base + 8'(i);
            tick();
            sb.push_back(base + 8'(i));
        end
        d0_wr_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        d0_af = 4'd0;
        tick();
        n_cmp++; if (d0_level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", d0_level); end
        n_cmp++; if (d0_empty !== 1'b1 || d0_full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got=%b%b exp=10", d0_empty, d0_full); end
        n_cmp++; if (d0_afl !== 1'b1) begin n_err++; $display("FAIL reset_af_thresh0 got=%b exp=1", d0_afl); end
        d0_af = 4'd8; #1;
        n_cmp++; if (d0_afl !== 1'b0 || d0_aem !== 1'b1) begin n_err++; $display("FAIL reset_af_ae got=%b%b exp=01", d0_afl, d0_aem); end
        n_cmp++; if (d0_rd_data !== 8'h00 || d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_err++; $display("FAIL reset_data_flags got=%h %b%b exp=00 00", d0_rd_data, d0_ovf, d0_unf); end
        n_cmp++; if (d1_rd_data !== 8'h00 || d1_empty !== 1'b1) begin n_err++; $display("FAIL reset_fwft got=%h %b exp=00 1", d1_rd_data, d1_empty); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            d0_wr_en = 1; d0_wr_data = 8'(i);
            tick();
            sb.push_back(8'(i));
            n_cmp++; if (d0_level !== 4'(i + 1)) begin n_err++; $display("FAIL fill_level got=%0d exp=%0d", d0_level, i + 1); end
        end
        d0_wr_en = 0;
        n_cmp++; if (d0_full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", d0_full); end
        for (int i = 0; i < 8; i++) begin
            d0_rd_en = 1;
            tick();
            exp_d = sb.pop_front();
            n_cmp++; if (d0_rd_data !== exp_d) begin n_err++; $display("FAIL drain_data got=%h exp=%h", d0_rd_data, exp_d); end
        end
        d0_rd_en = 0;
        n_cmp++; if (d0_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", d0_empty); end
        n_cmp++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_err++; $display("FAIL drain_flags got=%b%b exp=00", d0_ovf, d0_unf); end
    endtask

    task automatic test_full_rw();
        fill0(8'h00, 8);
        for (int i = 0; i < 3; i++) begin
            d0_wr_en = 1; d0_rd_en = 1; d0_wr_data = 8'hAA;
            tick();
            exp_d = sb.pop_front();
            sb.push_back(8'hAA);
            n_cmp++; if (d0_rd_data !== exp_d) begin n_err++; $display("FAIL fullrw_data got=%h exp=%h", d0_rd_data, exp_d); end
            n_cmp++; if (d0_level !== 4'd8 || d0_ovf !== 1'b0) begin n_err++; $display("FAIL fullrw_level_ovf got=%0d %b exp=8 0", d0_level, d0_ovf); end
        end
        d0_wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            d0_rd_en = 1;
            tick();
            exp_d = sb.pop_front();
            n_cmp++; if (d0_rd_data !== exp_d) begin n_err++; $display("FAIL fullrw_drain got=%h exp=%h", d0_rd_data, exp_d); end
        end
        d0_rd_en = 0;
    endtask

    task automatic test_errors();
        fill0(8'h40, 8);
        d0_wr_en = 1; d0_wr_data = 8'hEE;
        tick();
        d0_wr_en = 0;
        n_cmp++; if (d0_ovf !== 1'b1 || d0_level !== 4'd8) begin n_err++; $display("FAIL ovf_set got=%b %0d exp=1 8", d0_ovf, d0_level); end
        for (int i = 0; i < 8; i++) begin
            d0_rd_en = 1;
            tick();
            exp_d = sb.pop_front();
            n_cmp++; if (d0_rd_data !== exp_d) begin n_err++; $display("FAIL ovf_drain got=%h exp=%h", d0_rd_data, exp_d); end
        end
        n_cmp++; if (d0_unf !== 1'b0) begin n_err++; $display("FAIL unf_early got=%b exp=0", d0_unf); end
        tick();
        d0_rd_en = 0;
        n_cmp++; if (d0_unf !== 1'b1 || d0_level !== 4'd0) begin n_err++; $display("FAIL unf_set got=%b %0d exp=1 0", d0_unf, d0_level); end
        d0_err_clr = 1;
        tick();
        d0_err_clr = 0;
        n_cmp++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_err++; $display("FAIL err_clr got=%b%b exp=00", d0_ovf, d0_unf); end
        fill0(8'h50, 8);
        d0_wr_en = 1; d0_err_clr = 1;
        tick();
        d0_wr_en = 0; d0_err_clr = 0;
        n_cmp++; if (d0_ovf !== 1'b1) begin n_err++; $display("FAIL set_beats_clr got=%b exp=1", d0_ovf); end
        d0_flush = 1; d0_err_clr = 1;
        tick();
        d0_flush = 0; d0_err_clr = 0;
        sb.delete();
        n_cmp++; if (d0_ovf !== 1'b0 || d0_level !== 4'd0) begin n_err++; $display("FAIL flush_clr got=%b %0d exp=0 0", d0_ovf, d0_level); end
    endtask

    task automatic test_thresholds();
        d0_af = 4'd6; d0_ae = 4'd2; #1;
        n_cmp++; if (d0_aem !== 1'b1 || d0_afl !== 1'b0) begin n_err++; $display("FAIL thr_lvl0 got=%b%b exp=10", d0_aem, d0_afl); end
        for (int i = 1; i <= 6; i++) begin
            d0_wr_en = 1; d0_wr_data = 8'(i);
            tick();
            n_cmp++; if (d0_afl !== (i >= 6)) begin n_err++; $display("FAIL thr_af lvl=%0d got=%b exp=%b", i, d0_afl, (i >= 6)); end
            n_cmp++; if (d0_aem !== (i <= 2)) begin n_err++; $display("FAIL thr_ae lvl=%0d got=%b exp=%b", i, d0_aem, (i <= 2)); end
        end
        d0_wr_en = 0;
        d0_af = 4'd7; #1;
        n_cmp++; if (d0_afl !== 1'b0) begin n_err++; $display("FAIL thr_af_change got=%b exp=0", d0_afl); end
        d0_af = 4'd15; d0_ae = 4'd9;
        fill0(8'h00, 2);
        n_cmp++; if (d0_afl !== 1'b0 || d0_aem !== 1'b1 || d0_full !== 1'b1) begin n_err++; $display("FAIL thr_above_depth got=%b%b%b exp=011", d0_afl, d0_aem, d0_full); end
        d0_af = 4'd8; d0_ae = 4'd0;
        d0_flush = 1;
        tick();
        d0_flush = 0;
        sb.delete();
    endtask

    task automatic test_flush();
        fill0(8'h60, 6);
        d0_rd_en = 1;
        tick();
        d0_rd_en = 0;
        void'(sb.pop_front());
        n_cmp++; if (d0_rd_data !== 8'h60 || d0_level !== 4'd5) begin n_err++; $display("FAIL pre_flush got=%h %0d exp=60 5", d0_rd_data, d0_level); end
        d0_flush = 1; d0_wr_en = 1; d0_rd_en = 1; d0_wr_data = 8'h99;
        tick();
        n_cmp++; if (d0_level !== 4'd0 || d0_empty !== 1'b1 || d0_rd_data !== 8'h00) begin n_err++; $display("FAIL flush got=%0d %b %h exp=0 1 00", d0_level, d0_empty, d0_rd_data); end
        n_cmp++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_err++; $display("FAIL flush_flags got=%b%b exp=00", d0_ovf, d0_unf); end
        d0_wr_en = 0;
        tick();
        d0_flush = 0; d0_rd_en = 0;
        n_cmp++; if (d0_unf !== 1'b0) begin n_err++; $display("FAIL flush_empty_rd got=%b exp=0", d0_unf); end
        sb.delete();
    endtask

    task automatic test_fwft();
        d1_wr_en = 1; d1_wr_data = 8'h11;
        tick();
        n_cmp++; if (d1_rd_data !== 8'h11) begin n_err++; $display("FAIL fwft_first got=%h exp=11", d1_rd_data); end
        d1_wr_data = 8'h22;
        tick();
        d1_wr_en = 0;
        d1_rd_en = 1;
        tick();
        n_cmp++; if (d1_rd_data !== 8'h22) begin n_err++; $display("FAIL fwft_second got=%h exp=22", d1_rd_data); end
        tick();
        d1_rd_en = 0;
        n_cmp++; if (d1_rd_data !== 8'h00 || d1_empty !== 1'b1) begin n_err++; $display("FAIL fwft_empty got=%h %b exp=00 1", d1_rd_data, d1_empty); end
        for (int i = 0; i < 2; i++) begin
            d1_wr_en = 1; d1_wr_data = 8'h30 + 8'(i);
            tick();
            sb.push_back(8'h30 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            d1_wr_en = 1; d1_rd_en = 1; d1_wr_data = 8'h40 + 8'(i);
            tick();
            void'(sb.pop_front());
            sb.push_back(8'h40 + 8'(i));
            exp_d = sb[0];
            n_cmp++; if (d1_rd_data !== exp_d || d1_level !== 3'd2) begin n_err++; $display("FAIL fwft_wrap got=%h %0d exp=%h 2", d1_rd_data, d1_level, exp_d); end
        end
        d1_wr_en = 0;
        for (int i = 0; i < 2; i++) begin
            d1_rd_en = 1;
            tick();
            void'(sb.pop_front());
            exp_d = (sb.size() != 0) ? sb[0] : 8'h00;
            n_cmp++; if (d1_rd_data !== exp_d) begin n_err++; $display("FAIL fwft_drain got=%h exp=%h", d1_rd_data, exp_d); end
        end
        d1_rd_en = 0;
    endtask

    task automatic test_empty_rw();
        d1_wr_en = 1; d1_rd_en = 1; d1_wr_data = 8'h55;
        tick();
        d1_wr_en = 0; d1_rd_en = 0;
        n_cmp++; if (d1_level !== 3'd1 || d1_unf !== 1'b1 || d1_rd_data !== 8'h55) begin n_err++; $display("FAIL empty_rw got=%0d %b %h exp=1 1 55", d1_level, d1_unf, d1_rd_data); end
        d1_err_clr = 1; d1_rd_en = 1;
        tick();
        d1_err_clr = 0; d1_rd_en = 0;
        n_cmp++; if (d1_unf !== 1'b0 || d1_empty !== 1'b1) begin n_err++; $display("FAIL empty_rw_clr got=%b %b exp=0 1", d1_unf, d1_empty); end
    endtask

    task automatic test_reset_mid();
        d0_wr_en = 1; d1_wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            d0_wr_data = 8'h70 + 8'(i); d1_wr_data = 8'h80 + 8'(i);
            tick();
        end
        d0_wr_en = 0; d0_rd_en = 1;
        tick();
        d0_rd_en = 0;
        n_cmp++; if (d0_rd_data !== 8'h70 || d1_rd_data !== 8'h80) begin n_err++; $display("FAIL pre_reset got=%h %h exp=70 80", d0_rd_data, d1_rd_data); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (d0_level !== 4'd0 || d0_empty !== 1'b1 || d0_rd_data !== 8'h00) begin n_err++; $display("FAIL async_reset0 got=%0d %b %h exp=0 1 00", d0_level, d0_empty, d0_rd_data); end
        n_cmp++; if (d1_level !== 3'd0 || d1_rd_data !== 8'h00 || d1_full !== 1'b0) begin n_err++; $display("FAIL async_reset1 got=%0d %h %b exp=0 00 0", d1_level, d1_rd_data, d1_full); end
        d1_wr_en = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_errors();
        test_thresholds();
        test_flush();
        test_fwft();
        test_empty_rw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
